// File: rtl/rlwe_lsu_pkg.sv
// Shared encodings for the RLWE vector load/store unit: command set, FSM states,
// exception codes, DMEM channel encodings and command classification helpers.
package rlwe_lsu_pkg;

  typedef enum logic [2:0] {
    CMD_NONE = 3'd0,
    CMD_LW   = 3'd1,
    CMD_SW   = 3'd2,
    CMD_LV   = 3'd3,
    CMD_SV   = 3'd4,
    CMD_LVS  = 3'd5,
    CMD_SVS  = 3'd6
  } lsu_cmd_e;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } lsu_state_e;

  localparam logic [3:0] EXC_LD_MISALIGN = 4'd4;
  localparam logic [3:0] EXC_LD_ACCESS   = 4'd5;
  localparam logic [3:0] EXC_ST_MISALIGN = 4'd6;
  localparam logic [3:0] EXC_ST_ACCESS   = 4'd7;

  localparam logic MEM_RD     = 1'b0;
  localparam logic MEM_WR     = 1'b1;
  localparam logic MEM_WORD   = 1'b0;
  localparam logic MEM_VECTOR = 1'b1;

  localparam logic [1:0] RESP_NOTRDY = 2'd0;
  localparam logic [1:0] RESP_RDY_OK = 2'd1;
  localparam logic [1:0] RESP_RDY_ER = 2'd2;

  function automatic logic cmd_is_valid(input logic [2:0] cmd);
    return (cmd != CMD_NONE) && (cmd != 3'd7);
  endfunction

  function automatic logic cmd_is_store(input logic [2:0] cmd);
    return (cmd == CMD_SW) || (cmd == CMD_SV) || (cmd == CMD_SVS);
  endfunction

  function automatic logic cmd_is_vec(input logic [2:0] cmd);
    return (cmd == CMD_LV) || (cmd == CMD_SV);
  endfunction

  function automatic logic cmd_is_strided(input logic [2:0] cmd);
    return (cmd == CMD_LVS) || (cmd == CMD_SVS);
  endfunction

endpackage

// File: rtl/rlwe_lsu_agu.sv
// Beat address generator: base + element address + beat offset, wrapping mod 2^AWIDTH.
module rlwe_lsu_agu #(
  parameter int AWIDTH     = 32,
  parameter int BEAT_LANES = 2,
  parameter int IDXW       = 3
) (
  input  logic [AWIDTH-1:0] base,
  input  logic [31:0]       addr,
  input  logic [31:0]       stride,
  input  logic [IDXW-1:0]   beat,
  input  logic              strided,
  output logic [AWIDTH-1:0] beat_addr
);

  logic [31:0] beat_ext;
  logic [31:0] offset;

  always_comb begin
    beat_ext = 32'(beat);
    if (strided) begin
      offset = beat_ext * stride;
    end else begin
      offset = beat_ext * 32'(BEAT_LANES * 4);
    end
    beat_addr = base + AWIDTH'(addr) + AWIDTH'(offset);
  end

endmodule

// File: rtl/rlwe_vec_lsu.sv
// RLWE vector load/store unit: splits scalar, unit-stride and strided vector
// accesses into DMEM beats with one transaction outstanding at a time.
module rlwe_vec_lsu
  import rlwe_lsu_pkg::*;
#(
  parameter int                LANES      = 8,
  parameter int                BEAT_LANES = 2,
  parameter int                AWIDTH     = 32,
  parameter logic [AWIDTH-1:0] BASE_ADDR  = AWIDTH'(32'h0048_0000)
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic                    exu2lsu_req,
  input  logic [2:0]              exu2lsu_cmd,
  input  logic [31:0]             exu2lsu_addr,
  input  logic [31:0]             exu2lsu_stride,
  input  logic [LANES*32-1:0]     exu2lsu_s_data,
  output logic                    lsu2exu_rdy,
  output logic [LANES*32-1:0]     lsu2exu_l_data,
  output logic                    lsu2exu_exc,
  output logic [3:0]              lsu2exu_exc_code,
  output logic                    lsu_busy,
  output logic                    lsu2dmem_req,
  output logic                    lsu2dmem_cmd,
  output logic                    lsu2dmem_width,
  output logic [AWIDTH-1:0]       lsu2dmem_addr,
  output logic [BEAT_LANES*32-1:0] lsu2dmem_wdata,
  input  logic                    dmem2lsu_req_ack,
  input  logic [BEAT_LANES*32-1:0] dmem2lsu_rdata,
  input  logic [1:0]              dmem2lsu_resp
);

  localparam int IDXW      = $clog2(LANES);
  localparam int DW        = LANES * 32;
  localparam int BDW       = BEAT_LANES * 32;
  localparam int NBEAT_VEC = LANES / BEAT_LANES;
  localparam logic [31:0] VEC_MASK = (32'd1 << ($clog2(LANES) + 2)) - 32'd1;

  lsu_state_e      state_r, state_nx;
  logic [2:0]      cmd_r;
  logic [31:0]     addr_r, stride_r;
  logic [DW-1:0]   sdata_r, ldbuf_r;
  logic [IDXW-1:0] beat_r, last_idx;
  logic            err_r, misalign, misalign_exc, accept, last_beat;

  always_comb begin
    misalign = 1'b0;
    case (exu2lsu_cmd)
      CMD_LW, CMD_SW:   misalign = |exu2lsu_addr[1:0];
      CMD_LV, CMD_SV:   misalign = |(exu2lsu_addr & VEC_MASK);
      CMD_LVS, CMD_SVS: misalign = (|exu2lsu_addr[1:0]) | (|exu2lsu_stride[1:0]);
      default:          misalign = 1'b0;
    endcase
    misalign_exc = (state_r == ST_IDLE) && exu2lsu_req && cmd_is_valid(exu2lsu_cmd) && misalign;
  end

  always_comb begin
    if (cmd_is_vec(cmd_r)) begin
      last_idx = IDXW'(NBEAT_VEC - 1);
    end else if (cmd_is_strided(cmd_r)) begin
      last_idx = IDXW'(LANES - 1);
    end else begin
      last_idx = '0;
    end
    last_beat = (beat_r == last_idx);
  end

  always_comb begin
    state_nx = state_r;
    accept   = 1'b0;
    case (state_r)
      ST_IDLE: begin
        if (exu2lsu_req && cmd_is_valid(exu2lsu_cmd) && !misalign) begin
          accept   = 1'b1;
          state_nx = ST_REQ;
        end
      end
      ST_REQ: begin
        if (dmem2lsu_req_ack) state_nx = ST_WAIT;
      end
      ST_WAIT: begin
        case (dmem2lsu_resp)
          RESP_RDY_OK: state_nx = last_beat ? ST_DONE : ST_REQ;
          RESP_RDY_ER: state_nx = ST_DONE;
          default:     state_nx = ST_WAIT;
        endcase
      end
      ST_DONE: state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state_r <= ST_IDLE;
    else     state_r <= state_nx;
  end

  // Command latch, beat sequencing, load assembly and error capture.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cmd_r    <= 3'd0;
      addr_r   <= 32'd0;
      stride_r <= 32'd0;
      sdata_r  <= '0;
      ldbuf_r  <= '0;
      beat_r   <= '0;
      err_r    <= 1'b0;
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (accept) begin
            cmd_r    <= exu2lsu_cmd;
            addr_r   <= exu2lsu_addr;
            stride_r <= exu2lsu_stride;
            sdata_r  <= exu2lsu_s_data;
            ldbuf_r  <= '0;
            beat_r   <= '0;
            err_r    <= 1'b0;
          end
        end
        ST_WAIT: begin
          if (dmem2lsu_resp == RESP_RDY_OK) begin
            if (!cmd_is_store(cmd_r)) begin
              if (cmd_is_vec(cmd_r)) ldbuf_r[int'(beat_r)*BDW +: BDW] <= dmem2lsu_rdata;
              else                   ldbuf_r[int'(beat_r)*32 +: 32]   <= dmem2lsu_rdata[31:0];
            end
            if (!last_beat) beat_r <= beat_r + IDXW'(1);
          end else if (dmem2lsu_resp == RESP_RDY_ER) begin
            err_r <= 1'b1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  rlwe_lsu_agu #(
    .AWIDTH    (AWIDTH),
    .BEAT_LANES(BEAT_LANES),
    .IDXW      (IDXW)
  ) u_agu (
    .base     (BASE_ADDR),
    .addr     (addr_r),
    .stride   (stride_r),
    .beat     (beat_r),
    .strided  (cmd_is_strided(cmd_r)),
    .beat_addr(lsu2dmem_addr)
  );

  // Scalar and strided beats carry a single lane in slot 0.
  always_comb begin
    lsu2dmem_wdata = '0;
    if (cmd_is_vec(cmd_r)) begin
      lsu2dmem_wdata = sdata_r[int'(beat_r)*BDW +: BDW];
    end else begin
      lsu2dmem_wdata[31:0] = sdata_r[int'(beat_r)*32 +: 32];
    end
  end

  always_comb begin
    if (misalign_exc) begin
      lsu2exu_exc      = 1'b1;
      lsu2exu_exc_code = cmd_is_store(exu2lsu_cmd) ? EXC_ST_MISALIGN : EXC_LD_MISALIGN;
    end else if ((state_r == ST_DONE) && err_r) begin
      lsu2exu_exc      = 1'b1;
      lsu2exu_exc_code = cmd_is_store(cmd_r) ? EXC_ST_ACCESS : EXC_LD_ACCESS;
    end else begin
      lsu2exu_exc      = 1'b0;
      lsu2exu_exc_code = 4'd0;
    end
  end

  assign lsu2dmem_req   = (state_r == ST_REQ);
  assign lsu2dmem_cmd   = cmd_is_store(cmd_r) ? MEM_WR : MEM_RD;
  assign lsu2dmem_width = cmd_is_vec(cmd_r) ? MEM_VECTOR : MEM_WORD;
  assign lsu2exu_rdy    = (state_r == ST_DONE);
  assign lsu_busy       = (state_r != ST_IDLE);
  assign lsu2exu_l_data = ldbuf_r;

endmodule

// File: tb/tb_rlwe_vec_lsu.sv
// Scoreboard bench for rlwe_vec_lsu: a DMEM responder model, expectation queues
// filled at issue time, and a monitor that checks every request and completion.
module tb_rlwe_vec_lsu;

  localparam int LANES = 8;
  localparam int BL    = 2;

  typedef struct {
    logic        wr;
    logic        width;
    logic [31:0] addr;
    logic [63:0] wdata;
  } req_t;

  typedef struct {
    logic         exc;
    logic [3:0]   code;
    logic [255:0] ldata;
  } comp_t;

  logic           clk, rst;
  logic           exu2lsu_req;
  logic [2:0]     exu2lsu_cmd;
  logic [31:0]    exu2lsu_addr, exu2lsu_stride;
  logic [255:0]   exu2lsu_s_data;
  logic           lsu2exu_rdy, lsu2exu_exc, lsu_busy;
  logic [255:0]   lsu2exu_l_data;
  logic [3:0]     lsu2exu_exc_code;
  logic           lsu2dmem_req, lsu2dmem_cmd, lsu2dmem_width;
  logic [31:0]    lsu2dmem_addr;
  logic [63:0]    lsu2dmem_wdata;
  logic           dmem2lsu_req_ack;
  logic [63:0]    dmem2lsu_rdata;
  logic [1:0]     dmem2lsu_resp;

  int n_tests = 0;
  int n_fail  = 0;
  int ack_delay  = 0;
  int resp_delay = 0;
  int err_beat   = -1;
  req_t  req_q[$];
  comp_t comp_q[$];

  rlwe_vec_lsu #(.LANES(LANES), .BEAT_LANES(BL), .AWIDTH(32), .BASE_ADDR(32'h0048_0000)) dut (
    .clk(clk), .rst(rst),
    .exu2lsu_req(exu2lsu_req), .exu2lsu_cmd(exu2lsu_cmd), .exu2lsu_addr(exu2lsu_addr),
    .exu2lsu_stride(exu2lsu_stride), .exu2lsu_s_data(exu2lsu_s_data),
    .lsu2exu_rdy(lsu2exu_rdy), .lsu2exu_l_data(lsu2exu_l_data), .lsu2exu_exc(lsu2exu_exc),
    .lsu2exu_exc_code(lsu2exu_exc_code), .lsu_busy(lsu_busy),
    .lsu2dmem_req(lsu2dmem_req), .lsu2dmem_cmd(lsu2dmem_cmd), .lsu2dmem_width(lsu2dmem_width),
    .lsu2dmem_addr(lsu2dmem_addr), .lsu2dmem_wdata(lsu2dmem_wdata),
    .dmem2lsu_req_ack(dmem2lsu_req_ack), .dmem2lsu_rdata(dmem2lsu_rdata), .dmem2lsu_resp(dmem2lsu_resp)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return {a[15:0] ^ 16'hBEEF, a[15:0]};
  endfunction

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // DMEM model: ack after ack_delay stall cycles, respond resp_delay cycles later.
  initial begin
    int stall, wcnt, bcnt;
    logic pend;
    logic [63:0] pdata;
    stall = 0; wcnt = 0; bcnt = 0; pend = 1'b0; pdata = 64'd0;
    dmem2lsu_req_ack = 1'b0; dmem2lsu_resp = 2'd0; dmem2lsu_rdata = 64'd0;
    forever begin
      @(negedge clk);
      dmem2lsu_req_ack = 1'b0;
      dmem2lsu_resp    = 2'd0;
      if (!lsu_busy) bcnt = 0;
      if (pend) begin
        if (wcnt < resp_delay) wcnt++;
        else begin
          dmem2lsu_resp  = (bcnt == err_beat) ? 2'd2 : 2'd1;
          dmem2lsu_rdata = pdata;
          pend = 1'b0;
          bcnt++;
        end
      end else if (lsu2dmem_req) begin
        if (stall < ack_delay) stall++;
        else begin
          dmem2lsu_req_ack = 1'b1;
          stall = 0; wcnt = 0; pend = 1'b1;
          pdata = {mem_word(lsu2dmem_addr + 32'd4), mem_word(lsu2dmem_addr)};
        end
      end
    end
  end

  // Monitor: checks each presented request (every stall cycle) and each completion.
  initial begin
    req_t  er;
    comp_t ec;
    forever begin
      @(negedge clk);
      #1;
      if (!rst) begin
        if (lsu2dmem_req) begin
          if (req_q.size() == 0) check("unexpected_dmem_req", {lsu2dmem_addr}, 256'd0);
          else begin
            er = req_q[0];
            check("dmem_req", {lsu2dmem_cmd, lsu2dmem_width, lsu2dmem_addr,
                               lsu2dmem_cmd ? lsu2dmem_wdata : 64'd0},
                  {er.wr, er.width, er.addr, er.wdata});
            if (dmem2lsu_req_ack) void'(req_q.pop_front());
          end
        end
        if (lsu2exu_rdy) begin
          if (comp_q.size() == 0) check("unexpected_rdy", {lsu2exu_exc, lsu2exu_exc_code}, 256'd0);
          else begin
            ec = comp_q.pop_front();
            check("completion_exc", {lsu2exu_exc, lsu2exu_exc_code}, {ec.exc, ec.code});
            check("completion_ldata", lsu2exu_l_data, ec.ldata);
          end
        end
      end
    end
  end

  // Pushes the expected beats/completion, then pulses the command for one cycle.
  task automatic issue(input logic [2:0] cmd, input logic [31:0] addr, input logic [31:0] stride,
                       input logic [255:0] sdata, input int eb);
    int nb;
    logic vec, st;
    logic [31:0] a;
    logic [255:0] ld;
    req_t r;
    comp_t c;
    vec = (cmd == 3'd3) || (cmd == 3'd4);
    st  = (cmd == 3'd2) || (cmd == 3'd4) || (cmd == 3'd6);
    nb  = vec ? 4 : (((cmd == 3'd5) || (cmd == 3'd6)) ? 8 : 1);
    ld  = '0;
    for (int b = 0; b < nb; b++) begin
      if (eb >= 0 && b > eb) break;
      a = 32'h0048_0000 + addr + (vec ? 32'(b * 8) : 32'(b) * stride);
      r.wr = st; r.width = vec; r.addr = a; r.wdata = 64'd0;
      if (st) begin
        if (vec) r.wdata = sdata[b*64 +: 64];
        else     r.wdata[31:0] = sdata[b*32 +: 32];
      end
      req_q.push_back(r);
      if (!st && b != eb) begin
        if (vec) begin
          ld[(2*b)*32 +: 32]   = mem_word(a);
          ld[(2*b+1)*32 +: 32] = mem_word(a + 32'd4);
        end else begin
          ld[b*32 +: 32] = mem_word(a);
        end
      end
    end
    c.exc   = (eb >= 0) && (eb < nb);
    c.code  = c.exc ? (st ? 4'd7 : 4'd5) : 4'd0;
    c.ldata = ld;
    comp_q.push_back(c);
    err_beat = eb;
    exu2lsu_req = 1'b1; exu2lsu_cmd = cmd; exu2lsu_addr = addr;
    exu2lsu_stride = stride; exu2lsu_s_data = sdata;
    @(negedge clk);
    exu2lsu_req = 1'b0;
  endtask

  task automatic wait_done();
    for (int i = 0; i < 300 && comp_q.size() != 0; i++) @(negedge clk);
    check("completion_timeout", 256'(comp_q.size()), 256'd0);
  endtask

  task automatic check_misalign(input logic [2:0] cmd, input logic [31:0] addr,
                                input logic [31:0] stride, input logic [3:0] code);
    exu2lsu_req = 1'b1; exu2lsu_cmd = cmd; exu2lsu_addr = addr; exu2lsu_stride = stride;
    #1;
    check("misalign_exc", {lsu2exu_exc, lsu2exu_exc_code, lsu2dmem_req}, {1'b1, code, 1'b0});
    @(posedge clk);
    #1;
    exu2lsu_req = 1'b0;
    check("misalign_stays_idle", {lsu_busy, lsu2dmem_req, lsu2exu_rdy}, 256'd0);
    @(negedge clk);
  endtask

  initial begin
    logic [255:0] sd;
    rst = 1'b1; exu2lsu_req = 1'b0; exu2lsu_cmd = 3'd0; exu2lsu_addr = 32'd0;
    exu2lsu_stride = 32'd0; exu2lsu_s_data = '0;
    repeat (3) @(negedge clk);
    check("reset_ctrl", {lsu2exu_rdy, lsu2exu_exc, lsu2exu_exc_code, lsu2dmem_req, lsu_busy}, 256'd0);
    check("reset_ldata", lsu2exu_l_data, 256'd0);
    rst = 1'b0;
    @(negedge clk);

    // Unit-stride load: beats at 0x480040/48/50/58.
    issue(3'd3, 32'h40, 32'd0, '0, -1);
    wait_done();

    // Strided store with a 3-cycle ack stall; wdata is lane k in slot 0.
    for (int k = 0; k < LANES; k++) sd[k*32 +: 32] = 32'hC0DE_0000 + 32'(k);
    ack_delay = 3;
    issue(3'd6, 32'h100, 32'h20, sd, -1);
    wait_done();
    ack_delay = 0;

    for (int k = 0; k < LANES; k++) sd[k*32 +: 32] = 32'h1111_1111 * 32'(k + 1);
    issue(3'd4, 32'h80, 32'd0, sd, -1);
    wait_done();
    issue(3'd1, 32'h10C, 32'd0, '0, -1);
    wait_done();
    issue(3'd2, 32'h204, 32'd0, sd, -1);
    wait_done();

    check_misalign(3'd3, 32'h44, 32'd0, 4'd4);
    check_misalign(3'd4, 32'h48, 32'd0, 4'd6);
    check_misalign(3'd5, 32'h100, 32'h6, 4'd4);
    check_misalign(3'd2, 32'h102, 32'd0, 4'd6);

    // Strided load failing on beat 2: lanes 0-1 kept, no beat 3.
    issue(3'd5, 32'h200, 32'h10, '0, 2);
    wait_done();
    // Strided load whose addresses wrap past 2^32.
    issue(3'd5, 32'hFFFF_FFF0, 32'h8, '0, -1);
    wait_done();

    // Reset while waiting for a response; the late RDY_OK must be ignored.
    resp_delay = 4;
    issue(3'd1, 32'h300, 32'd0, '0, -1);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    req_q.delete();
    comp_q.delete();
    check("midreset_ctrl", {lsu2exu_rdy, lsu2exu_exc, lsu2exu_exc_code, lsu2dmem_req, lsu_busy}, 256'd0);
    check("midreset_ldata", lsu2exu_l_data, 256'd0);
    @(negedge clk);
    rst = 1'b0;
    repeat (6) @(negedge clk);
    check("late_resp_ignored", {lsu_busy, lsu2exu_rdy, lsu2exu_l_data}, 256'd0);
    resp_delay = 0;
    issue(3'd1, 32'h8, 32'd0, '0, -1);
    wait_done();

    check("req_queue_drained", 256'(req_q.size()), 256'd0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/rlwe_vec_lsu.md
RLWE_VEC_LSU -- requirements
Module: rlwe_vec_lsu

Interface
REQ-001 Parameter LANES, default 8: 32-bit lanes per vector; power of two, at least 2.
REQ-002 Parameter BEAT_LANES, default 2: lanes per DMEM beat; power of two; divides LANES.
REQ-003 Parameter AWIDTH, default 32: DMEM address width.
REQ-004 Parameter BASE_ADDR, default 'h480000: TCM base address added to every address.
REQ-005 clk  in  1  single clock; all state updates on rising edge.
REQ-006 rst  in  1  reset; asynchronous, active-high.
REQ-007 exu2lsu_req  in  1  command request.
REQ-008 exu2lsu_cmd  in  3  NONE, LW, SW, LV, SV, LVS (strided load), SVS (strided store).
REQ-009 exu2lsu_addr  in  32  base element address.
REQ-010 exu2lsu_stride  in  32  byte stride for LVS/SVS.
REQ-011 exu2lsu_s_data  in  LANES*32  store vector; lane i at bits [32i+31:32i].
REQ-012 lsu2exu_rdy  out  1  one-cycle completion pulse.
REQ-013 lsu2exu_l_data  out  LANES*32  registered load vector.
REQ-014 lsu2exu_exc  out  1  exception flag.
REQ-015 lsu2exu_exc_code  out  4  exception code.
REQ-016 lsu_busy  out  1  high whenever FSM is not IDLE.
REQ-017 lsu2dmem_req / cmd(RD,WR) / width(WORD,VECTOR) / addr[AWIDTH] / wdata[BEAT_LANES*32]  out: DMEM request channel.
REQ-018 dmem2lsu_req_ack  in  1;  dmem2lsu_rdata  in  BEAT_LANES*32;  dmem2lsu_resp  in  2 (NOTRDY, RDY_OK, RDY_ER).

Function
REQ-019 FSM states are IDLE, REQ, WAIT and DONE; at most one DMEM transaction is outstanding.
REQ-020 IDLE: on exu2lsu_req with cmd not NONE and no misalignment, latch cmd, addr, stride and s_data; clear beat counter and load buffer; go to REQ.
REQ-021 Misalignment is checked in IDLE only:
  - LW/SW: addr[1:0] nonzero.
  - LV/SV: addr[log2(LANES)+1:0] nonzero.
  - LVS/SVS: addr[1:0] or stride[1:0] nonzero.
REQ-022 Misalignment drives exc combinationally in the same cycle with code 4 (load) or 6 (store), issues no DMEM request and stays in IDLE.
REQ-023 REQ: lsu2dmem_req=1; addr, cmd, width and wdata are held stable until req_ack; on ack go to WAIT.
REQ-024 Beat count per command:
  - LV/SV: LANES/BEAT_LANES beats, width VECTOR.
  - LVS/SVS: LANES beats, width WORD.
  - LW/SW: 1 beat, width WORD.
REQ-025 Beat address, computed modulo 2^AWIDTH:
  - Unit-stride: BASE_ADDR + addr + beat*BEAT_LANES*4.
  - Strided: BASE_ADDR + addr + beat*stride (wraps silently).
REQ-026 Store wdata = latched lanes [beat*BEAT_LANES +: BEAT_LANES]; strided and scalar use lane [beat], placed in lane slot 0 with other slots zero.
REQ-027 WAIT with RDY_OK: loads write rdata to the matching buffer lanes; last beat goes to DONE, otherwise increment beat and go to REQ.
REQ-028 WAIT with NOTRDY: hold state.
REQ-029 WAIT with RDY_ER: abort remaining beats, latch error with code 5 (load) or 7 (store), go to DONE.
REQ-030 DONE: rdy=1 for exactly one cycle; exc=1 with the latched code if an error occurred; go to IDLE.
REQ-031 LW returns lane 0 with all other lanes zero; on error, lanes already loaded keep their values.
REQ-032 exu2lsu_req is ignored outside IDLE; back-to-back commands are accepted in the IDLE cycle after DONE.

Reset
REQ-033 rst asserted at any time, including mid-transaction, forces IDLE, zeroes the beat counter, load buffer and error latch, and drives rdy, exc, lsu2dmem_req and lsu_busy to 0; lsu2exu_exc_code resets to 0.
REQ-034 A DMEM response arriving after reset is ignored.

Structure
REQ-035 Package rlwe_lsu_pkg holds the cmd enum, FSM enum, exception-code constants, and the mem cmd, width and resp encodings.
REQ-036 Sub-module rlwe_lsu_agu computes the beat address from base, stride, beat index and mode; it is purely combinational.

Verification
REQ-037 LV, addr=0x40, LANES=8, BEAT_LANES=2, zero-wait DMEM -> 4 requests at 0x480040/48/50/58; rdy pulses once; l_data equals the memory image.
REQ-038 SVS, addr=0x100, stride=0x20, req_ack delayed 3 cycles -> 8 WORD writes at 0x480100 + 0x20*k with wdata=lane k; addr held stable during the stall.
REQ-039 LV, addr=0x44 -> exc=1 with code 4 in the same cycle; no lsu2dmem_req; stays IDLE.
REQ-040 LVS with RDY_ER on beat 2 -> no beat 3 request; rdy=1 and exc=1 with code 5; lanes 0-1 are loaded.
REQ-041 LVS, addr=0xFFFFFFF0, stride=0x8 -> beat addresses wrap mod 2^32 with no error.
REQ-042 rst asserted while in WAIT, then a late RDY_OK -> outputs at reset values; response ignored; next LW completes normally.
